nibble_serial_adder: RTL

//  Wide sequential adder that feeds the 4-bit carry-lookahead add stage one nibble per cycle.

---
 rtl/nibble_serial_adder_if.sv | 9 +
 rtl/nibble_serial_adder.sv | 76 +++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for nibble_serial_adder
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [WIDTH-1:0] a, b, sum;
    modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, busy);
    modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder pushing one nibble per cycle through a 4-bit lookahead stage
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [IW-1:0]    idx;
    logic             carry, cout_q, last;
    logic [WIDTH-1:0] ra, rb, acc, acc_n, sum_q;
    logic [3:0]       g, p;
    logic [4:0]       c;

    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state == RUN;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign last          = idx == IW'(N - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state == IDLE ? (bus.in_valid  ? RUN  : IDLE) :
                  state == RUN  ? (last          ? DONE : RUN)  :
                  state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
    end

    // operand registers shift right so the active nibble is always in bits [3:0]
    assign g = ra[3:0] & rb[3:0];
    assign p = ra[3:0] ^ rb[3:0];
    assign c[0] = carry;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

    always_comb begin
        acc_n = acc;
        acc_n[4*idx +: 4] = p ^ c[3:0];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            ra     <= '0;
            rb     <= '0;
            acc    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            ra    <= bus.a;
            rb    <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            ra    <= ra >> 4;
            rb    <= rb >> 4;
            acc   <= acc_n;
            carry <= c[4];
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                sum_q  <= acc_n;
                cout_q <= c[4];
            end
        end
endmodule
